// File: rtl/cache_pkg.sv
// cache_pkg: responder FSM state type and helpers that derive address field widths.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_WAIT,
        FETCH_RESP,
        WB_WAIT,
        WB_ACK
    } mem_state_t;

    // Number of byte-offset bits in a line address.
    function automatic int offset_bits(input int block_size);
        return $clog2(block_size);
    endfunction

    // Number of line-index bits needed to address the backing store.
    function automatic int index_bits(input int mem_blocks);
        return $clog2(mem_blocks);
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// mem_block_array: single-port synchronous line RAM, one read or write per cycle.
//   clk   in   clock, rising edge
//   en    in   access enable
//   we    in   1 = write wdata at addr, 0 = read addr into rdata
//   addr  in   line index
//   wdata in   line to write
//   rdata out  registered read line, held between reads
module mem_block_array #(
    parameter int LINE_WIDTH = 256,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LINE_WIDTH-1:0] wdata,
    output logic [LINE_WIDTH-1:0] rdata
);

    logic [LINE_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency main memory model answering line fetches and write-backs.
//   clk, reset                   clock and synchronous active-high reset
//   fetchRequest/fetchAddress    level fetch request and byte address
//   fetchValid/fetchedData       four-phase fetch response and returned line (zero when not valid)
//   writeBackRequest/Address/Data level write-back request, byte address and line
//   writeBackAck                 four-phase write-back acknowledge
//   busy                         responder is not idle
module main_memory_responder
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int MEM_BLOCKS    = 256,
    parameter int MEM_LATENCY   = 4,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetchRequest,
    input  logic [ADDRESS_WIDTH-1:0]  fetchAddress,
    output logic                      fetchValid,
    output logic [8*BLOCK_SIZE-1:0]   fetchedData,
    input  logic                      writeBackRequest,
    input  logic [ADDRESS_WIDTH-1:0]  writeBackAddress,
    input  logic [8*BLOCK_SIZE-1:0]   writeBackData,
    output logic                      writeBackAck,
    output logic                      busy
);

    localparam int OB = offset_bits(BLOCK_SIZE);
    localparam int IB = index_bits(MEM_BLOCKS);
    localparam int LW = 8 * BLOCK_SIZE;
    localparam logic [COUNTER_WIDTH-1:0] LOAD = COUNTER_WIDTH'(MEM_LATENCY - 1);

    mem_state_t             state;
    logic [COUNTER_WIDTH-1:0] count;
    logic [IB-1:0]          line;
    logic [LW-1:0]          wb_line;
    logic [LW-1:0]          rd_line;
    logic                   mem_en;
    logic                   mem_we;
    logic                   unused_addr_bits;

    // Offset and aliasing upper bits never select anything.
    assign unused_addr_bits = ^{fetchAddress, writeBackAddress};

    // The array access happens on the edge that leaves a WAIT state; a reset on
    // that same edge must suppress the write so the write-back is discarded.
    assign mem_we = state == WB_WAIT;
    assign mem_en = !reset && count == '0 && (state == FETCH_WAIT || state == WB_WAIT);

    mem_block_array #(
        .LINE_WIDTH(LW),
        .DEPTH     (MEM_BLOCKS),
        .ADDR_WIDTH(IB)
    ) u_array (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (line),
        .wdata(wb_line),
        .rdata(rd_line)
    );

    // The RAM output register holds the fetched line; gating keeps the bus zero when idle.
    assign fetchedData = fetchValid ? rd_line : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            fetchValid   <= 1'b0;
            writeBackAck <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (writeBackRequest) begin
                        line    <= writeBackAddress[OB +: IB];
                        wb_line <= writeBackData;
                        count   <= LOAD;
                        busy    <= 1'b1;
                        state   <= WB_WAIT;
                    end else if (fetchRequest) begin
                        line  <= fetchAddress[OB +: IB];
                        count <= LOAD;
                        busy  <= 1'b1;
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (count == '0) begin
                        fetchValid <= 1'b1;
                        state      <= FETCH_RESP;
                    end else count <= count - 1'b1;
                end
                WB_WAIT: begin
                    if (count == '0) begin
                        writeBackAck <= 1'b1;
                        state        <= WB_ACK;
                    end else count <= count - 1'b1;
                end
                FETCH_RESP: begin
                    if (!fetchRequest) begin
                        fetchValid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WB_ACK: begin
                    if (!writeBackRequest) begin
                        writeBackAck <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: self-checking bench for main_memory_responder (latency 4 and latency 1 builds).
module tb_main_memory_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetchRequest, writeBackRequest;
    logic [31:0]  fetchAddress, writeBackAddress;
    logic [255:0] writeBackData, fetchedData;
    logic         fetchValid, writeBackAck, busy;

    logic         f1_req, w1_req, f1_valid, w1_ack, busy1;
    logic [31:0]  f1_addr, w1_addr;
    logic [255:0] w1_data, f1_data;

    int checks = 0;
    int errors = 0;

    logic [255:0] model [256];

    always #5 clk = ~clk;

    main_memory_responder u_dut (
        .clk(clk), .reset(reset),
        .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
        .fetchValid(fetchValid), .fetchedData(fetchedData),
        .writeBackRequest(writeBackRequest), .writeBackAddress(writeBackAddress),
        .writeBackData(writeBackData), .writeBackAck(writeBackAck), .busy(busy)
    );

    main_memory_responder #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .fetchRequest(f1_req), .fetchAddress(f1_addr),
        .fetchValid(f1_valid), .fetchedData(f1_data),
        .writeBackRequest(w1_req), .writeBackAddress(w1_addr),
        .writeBackData(w1_data), .writeBackAck(w1_ack), .busy(busy1)
    );

    typedef struct {
        bit           wb;
        logic [31:0]  addr;
        logic [255:0] data;
        int           hold;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr / 32) % 256);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_wb(input logic [31:0] addr, input logic [255:0] data);
        int n;
        writeBackAddress = addr;
        writeBackData    = data;
        writeBackRequest = 1'b1;
        tick;
        chk("wb_busy", {255'd0, busy}, 256'd1);
        writeBackAddress = $urandom;
        writeBackData    = rand_line();
        n = 0;
        while (!writeBackAck && n < 20) begin
            tick;
            n++;
        end
        chk("wb_latency", n, LAT);
        model[idx_of(addr)] = data;
        writeBackRequest = 1'b0;
        tick;
        chk("wb_ack_drop", {255'd0, writeBackAck}, 256'd0);
        chk("wb_idle", {255'd0, busy}, 256'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int hold, input logic [255:0] exp);
        int n;
        fetchAddress = addr;
        fetchRequest = 1'b1;
        tick;
        chk("fetch_busy", {255'd0, busy}, 256'd1);
        chk("fetch_data_zero_wait", fetchedData, 256'd0);
        fetchAddress = $urandom;
        n = 0;
        while (!fetchValid && n < 20) begin
            tick;
            n++;
        end
        chk("fetch_latency", n, LAT);
        chk("fetch_data", fetchedData, exp);
        for (int h = 0; h < hold; h++) begin
            tick;
            chk("hold_valid", {255'd0, fetchValid}, 256'd1);
            chk("hold_data", fetchedData, exp);
        end
        fetchRequest = 1'b0;
        tick;
        chk("fetch_valid_drop", {255'd0, fetchValid}, 256'd0);
        chk("fetch_data_drop", fetchedData, 256'd0);
        tick;
        chk("fetch_no_second", {255'd0, busy}, 256'd0);
    endtask

    initial begin
        int n;
        logic [255:0] d;
        logic [31:0]  a;
        vecs[0] = '{1'b1, 32'h0000_0040, {32{8'hA5}}, 0};
        vecs[1] = '{1'b0, 32'h0000_0040, {32{8'hA5}}, 0};
        vecs[2] = '{1'b1, 32'h0000_0060, {8{32'hDEAD_BEEF}}, 0};
        vecs[3] = '{1'b0, 32'h0000_207F, {8{32'hDEAD_BEEF}}, 0};
        vecs[4] = '{1'b1, 32'h0000_0080, {16{16'h1234}}, 0};
        vecs[5] = '{1'b0, 32'h0000_0080, {16{16'h1234}}, 3};
        vecs[6] = '{1'b0, 32'h0000_005F, {32{8'hA5}}, 1};
        vecs[7] = '{1'b0, 32'hFFFF_E060, {8{32'hDEAD_BEEF}}, 0};

        reset = 1'b1;
        fetchRequest = 1'b0; writeBackRequest = 1'b0;
        fetchAddress = '0; writeBackAddress = '0; writeBackData = '0;
        f1_req = 1'b0; w1_req = 1'b0; f1_addr = '0; w1_addr = '0; w1_data = '0;
        tick;
        tick;
        chk("rst_valid", {255'd0, fetchValid}, 256'd0);
        chk("rst_ack", {255'd0, writeBackAck}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_data", fetchedData, 256'd0);
        chk("rst_busy1", {255'd0, busy1}, 256'd0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wb) do_wb(vecs[i].addr, vecs[i].data);
            else do_fetch(vecs[i].addr, vecs[i].hold, vecs[i].data);
        end

        // simultaneous requests to 0x100: write-back first, fetch then sees it
        d = {4{64'h0123_4567_89AB_CDEF}};
        fetchAddress = 32'h100; writeBackAddress = 32'h100; writeBackData = d;
        fetchRequest = 1'b1; writeBackRequest = 1'b1;
        tick;
        n = 0;
        while (!writeBackAck && n < 20) begin
            tick;
            n++;
        end
        chk("simul_wb_latency", n, LAT);
        chk("simul_no_fetch_yet", {255'd0, fetchValid}, 256'd0);
        model[idx_of(32'h100)] = d;
        writeBackRequest = 1'b0;
        tick;
        chk("simul_idle", {255'd0, busy}, 256'd0);
        tick;
        chk("simul_fetch_accept", {255'd0, busy}, 256'd1);
        n = 0;
        while (!fetchValid && n < 20) begin
            tick;
            n++;
        end
        chk("simul_fetch_latency", n, LAT);
        chk("simul_fetch_data", fetchedData, d);
        fetchRequest = 1'b0;
        tick;
        chk("simul_valid_drop", {255'd0, fetchValid}, 256'd0);

        // reset on the edge where the write would land: write discarded
        writeBackAddress = 32'h80; writeBackData = {256{1'b1}}; writeBackRequest = 1'b1;
        tick;
        repeat (3) tick;
        chk("rstwb_busy", {255'd0, busy}, 256'd1);
        chk("rstwb_ack_pre", {255'd0, writeBackAck}, 256'd0);
        reset = 1'b1;
        writeBackRequest = 1'b0;
        tick;
        chk("rstwb_ack", {255'd0, writeBackAck}, 256'd0);
        chk("rstwb_busy0", {255'd0, busy}, 256'd0);
        chk("rstwb_valid", {255'd0, fetchValid}, 256'd0);
        chk("rstwb_data", fetchedData, 256'd0);
        reset = 1'b0;
        tick;
        do_fetch(32'h80, 0, {16{16'h1234}});

        // randomized traffic on lines 16..31 against the array model
        for (int i = 0; i < 16; i++)
            do_wb(($urandom & 32'hFFFF_E000) | ((16 + i) << 5) | $urandom_range(0, 31), rand_line());
        for (int i = 0; i < 40; i++) begin
            a = ($urandom & 32'hFFFF_E000) | ($urandom_range(16, 31) << 5) | $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) do_wb(a, rand_line());
            else do_fetch(a, $urandom_range(0, 2), model[idx_of(a)]);
        end

        // latency-1 build: response one edge after acceptance, transfers every 3 cycles
        d = {8{32'hCAFE_F00D}};
        w1_addr = 32'h20; w1_data = d; w1_req = 1'b1;
        tick;
        chk("l1_wb_busy", {255'd0, busy1}, 256'd1);
        chk("l1_wb_ack0", {255'd0, w1_ack}, 256'd0);
        tick;
        chk("l1_wb_ack1", {255'd0, w1_ack}, 256'd1);
        w1_req = 1'b0;
        f1_addr = 32'h3F; f1_req = 1'b1;
        tick;
        chk("l1_wb_ack_drop", {255'd0, w1_ack}, 256'd0);
        chk("l1_idle", {255'd0, busy1}, 256'd0);
        tick;
        chk("l1_fetch_busy", {255'd0, busy1}, 256'd1);
        chk("l1_fetch_valid0", {255'd0, f1_valid}, 256'd0);
        tick;
        chk("l1_fetch_valid1", {255'd0, f1_valid}, 256'd1);
        chk("l1_fetch_data", f1_data, d);
        f1_req = 1'b0;
        tick;
        chk("l1_fetch_drop", {255'd0, f1_valid}, 256'd0);
        chk("l1_fetch_idle", {255'd0, busy1}, 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
